// File: rtl/pkt_writer_pkg.sv
// Shared types and constants for the packet capture writer and its register bank.
package pkt_writer_pkg;

    // Encoding matches control[1:0] as published by the register bank.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CAPTURE = 2'b01,
        ST_DONE    = 2'b10,
        ST_ERROR   = 2'b11
    } state_t;

    localparam int CTRL_START_BIT = 2;

    localparam int REG_CONTROL       = 0;
    localparam int REG_PKT_BEGIN     = 1;
    localparam int REG_PKT_END       = 2;
    localparam int REG_WRITE_ADDRESS = 3;

endpackage

// File: rtl/pkt_writer_addr_gen.sv
// Write pointer for the capture buffer: increment, limit compare, optional ring wrap.
// PKT_WRITER_WRAP_EN selects ring-buffer mode; otherwise reaching the limit reports full.
module pkt_writer_addr_gen #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         advance,
    input  logic         sop_mark,
    input  logic [N-1:0] base_address,
    input  logic [N-1:0] limit_address,
    output logic [N-1:0] ptr_eff,
    output logic         full,
    output logic         overwrite
);
`ifdef PKT_WRITER_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic [N-1:0] pointer;
    logic [N-1:0] pkt_start;
    logic [N-1:0] ptr_inc;
    logic         wrap_hit;
    logic         wrapped_q;
    logic         ovw_q;
    logic         ovw_hit;

    assign ptr_inc  = pointer + N'(N / 8);
    assign wrap_hit = ptr_inc >= limit_address;
    // ptr_eff is the address a word accepted this cycle will be written to.
    assign ptr_eff  = !advance ? pointer : ((WRAP && wrap_hit) ? base_address : ptr_inc);
    assign full     = advance && wrap_hit && !WRAP;
    assign ovw_hit  = wrapped_q && advance && (pointer == pkt_start);
    assign overwrite = ovw_q || ovw_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            pointer   <= '0;
            pkt_start <= '0;
            wrapped_q <= 1'b0;
            ovw_q     <= 1'b0;
        end else if (load) begin
            pointer   <= base_address;
            pkt_start <= base_address;
            wrapped_q <= 1'b0;
            ovw_q     <= 1'b0;
        end else begin
            pointer <= ptr_eff;
            if (sop_mark) begin
                pkt_start <= ptr_eff;
                wrapped_q <= 1'b0;
                ovw_q     <= 1'b0;
            end else begin
                if (advance && wrap_hit && WRAP) wrapped_q <= 1'b1;
                if (ovw_hit) ovw_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pkt_writer.sv
// Avalon-MM write master storing captured packet words into the SDRAM buffer.
// Optional ring-buffer mode via PKT_WRITER_WRAP_EN (see pkt_writer_addr_gen).
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for a start rising edge
// ST_CAPTURE | accepting stream words and writing them to SDRAM
// ST_DONE    | eop word committed; hold until start drops
// ST_ERROR   | bad limits, buffer full, overlong packet or ring overwrite
module pkt_writer
    import pkt_writer_pkg::*;
#(
    parameter int N             = 32,
    parameter int MAX_PKT_WORDS = 512
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      start,
    input  logic [N-1:0]                              base_address,
    input  logic [N-1:0]                              limit_address,
    output logic [1:0]                                state,
    output logic [N-1:0]                              bytes_written,
    input  logic [N-1:0]                              in_data,
    input  logic                                      in_valid,
    input  logic                                      in_sop,
    input  logic                                      in_eop,
    input  logic [((N/8) > 1 ? $clog2(N/8) : 1)-1:0]  in_empty,
    output logic                                      in_ready,
    output logic [N-1:0]                              avm_address,
    output logic                                      avm_write,
    output logic [N-1:0]                              avm_writedata,
    output logic [N/8-1:0]                            avm_byteenable,
    input  logic                                      avm_waitrequest
);
    localparam int BYTES = N / 8;
    localparam int CW    = $clog2(MAX_PKT_WORDS + 1);
    localparam logic [BYTES-1:0] BE_ALL = '1;

    state_t          state_q, state_d;
    logic            start_q;
    logic            in_pkt;
    logic            avm_eop;
    logic [CW-1:0]   wcnt;
    logic [N-1:0]    ptr_eff;
    logic            full;
    logic            overwrite;
    logic            arm, complete, accept, keep, cnt_over;
    logic [BYTES-1:0] be_mask;

    function automatic logic [N-1:0] popcount(input logic [BYTES-1:0] v);
        logic [N-1:0] c;
        c = '0;
        for (int i = 0; i < BYTES; i++) c = c + N'(v[i]);
        return c;
    endfunction

    assign state    = state_q;
    assign complete = avm_write && !avm_waitrequest;
    assign in_ready = (state_q == ST_CAPTURE) && (!avm_write || !avm_waitrequest);
    assign accept   = in_valid && in_ready;
    // Words before the first sop are consumed but never written.
    assign keep     = accept && (in_sop || in_pkt);
    assign arm      = (state_q == ST_IDLE) && start && !start_q;
    assign cnt_over = keep && !in_sop && (wcnt == CW'(MAX_PKT_WORDS));
    assign be_mask  = BE_ALL >> in_empty;

    pkt_writer_addr_gen #(.N(N)) u_addr_gen (
        .clk           (clk),
        .reset         (reset),
        .load          (arm),
        .advance       (complete),
        .sop_mark      (keep && in_sop),
        .base_address  (base_address),
        .limit_address (limit_address),
        .ptr_eff       (ptr_eff),
        .full          (full),
        .overwrite     (overwrite)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arm) state_d = (limit_address <= base_address) ? ST_ERROR : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (complete && avm_eop)                    state_d = overwrite ? ST_ERROR : ST_DONE;
                else if (complete && full)                  state_d = ST_ERROR;
                else if (!start && (!avm_write || complete)) state_d = ST_IDLE;
                else if (cnt_over)                          state_d = ST_ERROR;
            end
            ST_DONE, ST_ERROR: begin
                if (!start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_q        <= 1'b0;
            in_pkt         <= 1'b0;
            wcnt           <= '0;
            bytes_written  <= '0;
            avm_write      <= 1'b0;
            avm_address    <= '0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
            avm_eop        <= 1'b0;
        end else begin
            start_q <= start;
            if (arm) begin
                bytes_written <= '0;
                in_pkt        <= 1'b0;
            end
            if (complete) begin
                bytes_written <= bytes_written + popcount(avm_byteenable);
                avm_write     <= 1'b0;
            end
            if (accept) begin
                if (in_sop) begin
                    in_pkt <= !in_eop;
                    wcnt   <= CW'(1);
                end else if (in_pkt) begin
                    in_pkt <= !in_eop;
                    wcnt   <= wcnt + 1'b1;
                end
            end
            if (keep && state_d == ST_CAPTURE) begin
                avm_write      <= 1'b1;
                avm_address    <= ptr_eff;
                avm_writedata  <= in_data;
                avm_byteenable <= in_eop ? be_mask : BE_ALL;
                avm_eop        <= in_eop;
            end
            // Leaving capture only happens with no write stalled, so this never breaks a hold.
            if (state_d != ST_CAPTURE) avm_write <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pkt_writer.sv
// Directed bench for pkt_writer: hand-computed expectations checked with immediate assertions.
module tb_pkt_writer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_address = '0;
    logic [31:0] limit_address = '0;
    logic [1:0]  state;
    logic [31:0] bytes_written;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_sop = 1'b0;
    logic        in_eop = 1'b0;
    logic [1:0]  in_empty = '0;
    logic        in_ready;
    logic [31:0] avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] log_addr [16];
    logic [31:0] log_data [16];
    logic [3:0]  log_be   [16];
    int          log_n = 0;

    pkt_writer dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .base_address    (base_address),
        .limit_address   (limit_address),
        .state           (state),
        .bytes_written   (bytes_written),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_sop          (in_sop),
        .in_eop          (in_eop),
        .in_empty        (in_empty),
        .in_ready        (in_ready),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest)
    );

    always #5 clk = ~clk;

    // Inputs change just after posedge, so at negedge the handshake for the next edge is settled.
    always @(negedge clk) begin
        if (!reset && avm_write && !avm_waitrequest) begin
            if (log_n < 16) begin
                log_addr[log_n] = avm_address;
                log_data[log_n] = avm_writedata;
                log_be[log_n]   = avm_byteenable;
            end
            log_n = log_n + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic arm(input logic [31:0] b, input logic [31:0] l);
        in_valid = 1'b0;
        start = 1'b0;
        tick();
        tick();
        base_address = b;
        limit_address = l;
        start = 1'b1;
        tick();
    endtask

    task automatic send(input logic [31:0] d, input logic s, input logic e, input logic [1:0] emp);
        int n = 0;
        in_data = d; in_sop = s; in_eop = e; in_empty = emp; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_ready_timeout", 32'(n < 50), 32'd1);
        tick();
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_empty = '0;
    endtask

    task automatic wait_state(input logic [1:0] exp, input string tag);
        int n = 0;
        while (state !== exp && n < 40) begin
            tick();
            n++;
        end
        check(tag, 32'(state), 32'(exp));
    endtask

    initial begin
        repeat (3) tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_avm_write", 32'(avm_write), 32'd0);
        check("rst_avm_address", avm_address, 32'd0);
        check("rst_avm_writedata", avm_writedata, 32'd0);
        check("rst_byteenable", 32'(avm_byteenable), 32'd0);
        check("rst_bytes_written", bytes_written, 32'd0);
        reset = 1'b0;
        tick();

        // basic 4-word packet
        arm(32'h1000, 32'h2000);
        check("t1_state_capture", 32'(state), 32'd1);
        log_n = 0;
        send(32'hA000_0000, 1'b1, 1'b0, 2'd0);
        send(32'hA000_0001, 1'b0, 1'b0, 2'd0);
        send(32'hA000_0002, 1'b0, 1'b0, 2'd0);
        send(32'hA000_0003, 1'b0, 1'b1, 2'd0);
        wait_state(2'd2, "t1_state_done");
        check("t1_count", 32'(log_n), 32'd4);
        check("t1_addr0", log_addr[0], 32'h1000);
        check("t1_addr1", log_addr[1], 32'h1004);
        check("t1_addr2", log_addr[2], 32'h1008);
        check("t1_addr3", log_addr[3], 32'h100C);
        check("t1_data2", log_data[2], 32'hA000_0002);
        check("t1_be0", 32'(log_be[0]), 32'hF);
        check("t1_be3", 32'(log_be[3]), 32'hF);
        check("t1_bytes", bytes_written, 32'd16);
        check("t1_ready_done", 32'(in_ready), 32'd0);

        // 3-cycle stall on the second write
        arm(32'h1000, 32'h2000);
        log_n = 0;
        send(32'hB000_0000, 1'b1, 1'b0, 2'd0);
        send(32'hB000_0001, 1'b0, 1'b0, 2'd0);
        avm_waitrequest = 1'b1;
        in_data = 32'hB000_0002; in_sop = 1'b0; in_eop = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_stall_addr", avm_address, 32'h1004);
            check("t2_stall_data", avm_writedata, 32'hB000_0001);
            check("t2_stall_write", 32'(avm_write), 32'd1);
            check("t2_stall_ready", 32'(in_ready), 32'd0);
            tick();
        end
        avm_waitrequest = 1'b0;
        tick();
        in_valid = 1'b0;
        send(32'hB000_0003, 1'b0, 1'b1, 2'd0);
        wait_state(2'd2, "t2_state_done");
        check("t2_count", 32'(log_n), 32'd4);
        check("t2_addr1", log_addr[1], 32'h1004);
        check("t2_data1", log_data[1], 32'hB000_0001);
        check("t2_addr2", log_addr[2], 32'h1008);
        check("t2_data2", log_data[2], 32'hB000_0002);
        check("t2_data3", log_data[3], 32'hB000_0003);
        check("t2_bytes", bytes_written, 32'd16);

        // eop with 3 empty bytes
        arm(32'h1000, 32'h2000);
        log_n = 0;
        send(32'hC000_0000, 1'b1, 1'b0, 2'd0);
        send(32'hC000_0001, 1'b0, 1'b0, 2'd0);
        send(32'hC000_0002, 1'b0, 1'b0, 2'd0);
        send(32'hC000_0003, 1'b0, 1'b1, 2'd3);
        wait_state(2'd2, "t3_state_done");
        check("t3_be_last", 32'(log_be[3]), 32'h1);
        check("t3_bytes", bytes_written, 32'd13);

        // buffer of two words, four-word packet driven back to back
        arm(32'h1000, 32'h1008);
        log_n = 0;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'hD000_0000 + 32'(i);
            in_sop = (i == 0); in_eop = (i == 3); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        wait_state(2'd3, "t4_state_error");
        repeat (3) tick();
`ifdef PKT_WRITER_WRAP_EN
        check("t4_count", 32'(log_n), 32'd4);
        check("t4_addr0", log_addr[0], 32'h1000);
        check("t4_addr1", log_addr[1], 32'h1004);
        check("t4_addr2", log_addr[2], 32'h1000);
        check("t4_addr3", log_addr[3], 32'h1004);
        check("t4_data3", log_data[3], 32'hD000_0003);
`else
        check("t4_count", 32'(log_n), 32'd2);
        check("t4_addr0", log_addr[0], 32'h1000);
        check("t4_addr1", log_addr[1], 32'h1004);
        check("t4_data1", log_data[1], 32'hD000_0001);
        check("t4_bytes", bytes_written, 32'd8);
`endif
        check("t4_write_low", 32'(avm_write), 32'd0);

        // limit not above base
        arm(32'h1000, 32'h1000);
        check("t5_bad_limit", 32'(state), 32'd3);

        // words before sop are dropped; rearm resets bytes and pointer
        arm(32'h1000, 32'h2000);
        log_n = 0;
        send(32'hE000_0000, 1'b0, 1'b0, 2'd0);
        send(32'hE000_0001, 1'b0, 1'b0, 2'd0);
        send(32'hE000_0002, 1'b1, 1'b0, 2'd0);
        send(32'hE000_0003, 1'b0, 1'b1, 2'd0);
        wait_state(2'd2, "t6_state_done");
        check("t6_count", 32'(log_n), 32'd2);
        check("t6_addr0", log_addr[0], 32'h1000);
        check("t6_data0", log_data[0], 32'hE000_0002);
        check("t6_addr1", log_addr[1], 32'h1004);
        check("t6_data1", log_data[1], 32'hE000_0003);
        check("t6_bytes", bytes_written, 32'd8);
        start = 1'b0;
        tick();
        tick();
        check("t6_idle", 32'(state), 32'd0);
        check("t6_bytes_hold", bytes_written, 32'd8);
        start = 1'b1;
        tick();
        check("t6_rearm_state", 32'(state), 32'd1);
        check("t6_rearm_bytes", bytes_written, 32'd0);
        log_n = 0;
        send(32'hE000_0010, 1'b1, 1'b1, 2'd0);
        wait_state(2'd2, "t6_single_done");
        check("t6_rearm_addr", log_addr[0], 32'h1000);
        check("t6_single_bytes", bytes_written, 32'd4);

        // packet one word longer than the limit
        arm(32'h0, 32'h10000);
        log_n = 0;
        for (int i = 0; i < 513; i++) begin
            in_data = 32'(i); in_sop = (i == 0); in_eop = 1'b0; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0; in_sop = 1'b0;
        wait_state(2'd3, "t7_state_error");
        check("t7_count", 32'(log_n), 32'd512);
        check("t7_bytes", bytes_written, 32'd2048);

        // reset while a write is stalled
        arm(32'h1000, 32'h2000);
        avm_waitrequest = 1'b1;
        send(32'hF000_0000, 1'b1, 1'b0, 2'd0);
        @(negedge clk);
        check("t8_pending", 32'(avm_write), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        check("t8_write_dropped", 32'(avm_write), 32'd0);
        check("t8_state_idle", 32'(state), 32'd0);
        check("t8_ready", 32'(in_ready), 32'd0);
        check("t8_address", avm_address, 32'd0);
        avm_waitrequest = 1'b0;
        reset = 1'b0;
        start = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
